// File: rtl/syn_weight_update.sv
// Per-synapse weight register. Inc/dec requests are held until the gamma-cycle pulse, then committed with saturation.
// Optional commit counters inc_cnt/dec_cnt are present when WUPD_STATS_EN is defined.
module syn_weight_update #(
    parameter int WRES  = 3,
    parameter int WINIT = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            grst,
    input  logic            inc,
    input  logic            dec,
    input  logic            learn_en,
    input  logic            load_valid,
    input  logic [WRES-1:0] load_data,
    output logic            load_ready,
    output logic [WRES-1:0] weight_out,
    output logic            sat_hi,
    output logic            sat_lo
`ifdef WUPD_STATS_EN
    ,
    output logic [15:0]     inc_cnt,
    output logic [15:0]     dec_cnt
`endif
);

    localparam logic [WRES-1:0] WMAX   = '1;
    localparam logic [WRES-1:0] WINITV = WRES'(WINIT);

    // COMMIT is never stored: it is the grst cycle seen while the register holds ACCUM.
    typedef enum logic [1:0] {
        ACCUM,
        COMMIT,
        LOAD
    } state_e;

    state_e          state_q, state_d, phase;
    logic [WRES-1:0] weight_q, weight_d;
    logic            inc_pend_q, inc_pend_d;
    logic            dec_pend_q, dec_pend_d;
    logic            load_accept;
    logic            commit_up, commit_dn;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        phase       = state_q;
        state_d     = state_q;
        load_ready  = 1'b0;
        load_accept = 1'b0;
        commit_up   = 1'b0;
        commit_dn   = 1'b0;
        weight_d    = weight_q;
        inc_pend_d  = inc_pend_q | inc;
        dec_pend_d  = dec_pend_q | dec;

        if (state_q == ACCUM && grst) begin
            phase = COMMIT;
        end

        unique case (phase)
            ACCUM: begin
                load_ready  = ~rst;
                load_accept = load_valid & ~rst;
                if (load_accept) begin
                    state_d = LOAD;
                end
            end
            COMMIT:  state_d = ACCUM;
            LOAD:    state_d = ACCUM;
            default: state_d = ACCUM;
        endcase

        if (grst) begin
            // Requests arriving in the grst cycle itself still count toward this commit.
            commit_up  = learn_en & (inc_pend_q | inc) & ~(dec_pend_q | dec);
            commit_dn  = learn_en & (dec_pend_q | dec) & ~(inc_pend_q | inc);
            inc_pend_d = 1'b0;
            dec_pend_d = 1'b0;
            if (commit_up && weight_q != WMAX) begin
                weight_d = weight_q + 1'b1;
            end else if (commit_dn && weight_q != '0) begin
                weight_d = weight_q - 1'b1;
            end
        end else if (load_accept) begin
            weight_d   = load_data;
            inc_pend_d = 1'b0;
            dec_pend_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ACCUM;
            weight_q   <= WINITV;
            inc_pend_q <= 1'b0;
            dec_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            weight_q   <= weight_d;
            inc_pend_q <= inc_pend_d;
            dec_pend_q <= dec_pend_d;
        end
    end

    assign weight_out = weight_q;
    assign sat_hi     = (weight_q == WMAX);
    assign sat_lo     = (weight_q == '0);

`ifdef WUPD_STATS_EN
    logic [15:0] inc_cnt_q, dec_cnt_q;

    // Saturated commits still count: they are effective requests even when the weight cannot move.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inc_cnt_q <= '0;
            dec_cnt_q <= '0;
        end else begin
            if (commit_up && inc_cnt_q != 16'hFFFF) begin
                inc_cnt_q <= inc_cnt_q + 16'd1;
            end
            if (commit_dn && dec_cnt_q != 16'hFFFF) begin
                dec_cnt_q <= dec_cnt_q + 16'd1;
            end
        end
    end

    assign inc_cnt = inc_cnt_q;
    assign dec_cnt = dec_cnt_q;
`endif

endmodule

// File: tb/tb_syn_weight_update.sv
// Scoreboard bench for syn_weight_update: directed scenarios then random traffic against a behavioural model.
module tb_syn_weight_update;

    localparam int WRES  = 3;
    localparam int WINIT = 0;
    localparam int WMAX  = (1 << WRES) - 1;

    logic            clk;
    logic            rst;
    logic            grst;
    logic            inc;
    logic            dec;
    logic            learn_en;
    logic            load_valid;
    logic [WRES-1:0] load_data;
    logic            load_ready;
    logic [WRES-1:0] weight_out;
    logic            sat_hi;
    logic            sat_lo;
`ifdef WUPD_STATS_EN
    logic [15:0]     inc_cnt;
    logic [15:0]     dec_cnt;
`endif

    syn_weight_update #(.WRES(WRES), .WINIT(WINIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .grst       (grst),
        .inc        (inc),
        .dec        (dec),
        .learn_en   (learn_en),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .weight_out (weight_out),
        .sat_hi     (sat_hi),
        .sat_lo     (sat_lo)
`ifdef WUPD_STATS_EN
        ,
        .inc_cnt    (inc_cnt),
        .dec_cnt    (dec_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int weight;
        bit ready;
        int icnt;
        int dcnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass   = 0;
    int   n_checks = 0;

    // Behavioural model: weight, pending requests, whether the last cycle accepted a load, counters.
    int m_w;
    bit m_ip, m_dp, m_loading;
    int m_ic, m_dc;

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    endtask

    task automatic model_reset();
        m_w = WINIT; m_ip = 0; m_dp = 0; m_loading = 0; m_ic = 0; m_dc = 0;
    endtask

    task automatic model_step(input bit g, input bit i, input bit d, input bit l,
                              input bit lv, input int ld);
        bit up, dn, accept;
        accept = lv && !m_loading && !g;
        if (g) begin
            up = (m_ip || i) && !(m_dp || d);
            dn = (m_dp || d) && !(m_ip || i);
            if (l && up) begin
                m_w  = (m_w + 1 > WMAX) ? WMAX : m_w + 1;
                m_ic = (m_ic == 65535) ? 65535 : m_ic + 1;
            end else if (l && dn) begin
                m_w  = (m_w - 1 < 0) ? 0 : m_w - 1;
                m_dc = (m_dc == 65535) ? 65535 : m_dc + 1;
            end
            m_ip = 0; m_dp = 0;
        end else if (accept) begin
            m_w = ld; m_ip = 0; m_dp = 0;
        end else begin
            m_ip = m_ip || i;
            m_dp = m_dp || d;
        end
        m_loading = accept;
    endtask

    // Called 1 time unit after a rising edge: drives one cycle and records what the DUT must show in it.
    task automatic cycle(input bit g, input bit i, input bit d, input bit l,
                         input bit lv, input int ld);
        exp_t e;
        grst = g; inc = i; dec = d; learn_en = l; load_valid = lv;
        load_data = ld[WRES-1:0];
        e.weight = m_w;
        e.ready  = !m_loading && !g;
        e.icnt   = m_ic;
        e.dcnt   = m_dc;
        sb_q.push_back(e);
        @(posedge clk);
        model_step(g, i, d, l, lv, ld);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, 0, 0, 1, 0, 0);
    endtask

    // Asynchronous reset asserted mid-cycle; weight must drop to WINIT before the next edge.
    task automatic async_reset();
        exp_t e;
        grst = 0; inc = 0; dec = 0; learn_en = 1; load_valid = 0; load_data = '0;
        #2 rst = 1'b1;
        #1;
        check("async_rst_weight", int'(weight_out), WINIT);
        check("async_rst_ready", int'(load_ready), 0);
        model_reset();
        e.weight = m_w; e.ready = 0; e.icnt = 0; e.dcnt = 0;
        sb_q.push_back(e);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("weight_out", int'(weight_out), e.weight);
                check("sat_hi", int'(sat_hi), int'(e.weight == WMAX));
                check("sat_lo", int'(sat_lo), int'(e.weight == 0));
                check("load_ready", int'(load_ready), int'(e.ready));
`ifdef WUPD_STATS_EN
                check("inc_cnt", int'(inc_cnt), e.icnt);
                check("dec_cnt", int'(dec_cnt), e.dcnt);
`endif
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int ld;
        rst = 1'b1; grst = 0; inc = 0; dec = 0; learn_en = 1; load_valid = 0; load_data = '0;
        #3;
        check("por_weight", int'(weight_out), WINIT);
        check("por_ready", int'(load_ready), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();

        // Single inc mid-gamma commits to 1; a later empty grst proves the flags were cleared.
        cycle(0, 1, 0, 1, 0, 0); idle(1); cycle(1, 0, 0, 1, 0, 0); idle(2);
        cycle(1, 0, 0, 1, 0, 0); idle(1);
        // inc and dec on different cycles cancel.
        cycle(0, 1, 0, 1, 0, 0); idle(1); cycle(0, 0, 1, 1, 0, 0); cycle(1, 0, 0, 1, 0, 0); idle(1);
        // Load 7, then inc with grst saturates at wmax.
        cycle(0, 0, 0, 1, 1, 7); idle(1); cycle(1, 1, 0, 1, 0, 0); idle(1);
        // Load issued during grst stalls one cycle.
        cycle(1, 0, 0, 1, 1, 5); cycle(0, 0, 0, 1, 1, 5); idle(2);
        // learn_en low suppresses the commit but still clears the dec request.
        cycle(0, 0, 0, 1, 1, 3); idle(1); cycle(0, 0, 1, 0, 0, 0); cycle(1, 0, 0, 0, 0, 0); idle(1);
        cycle(1, 0, 0, 1, 0, 0); idle(1);
        // Reset with an inc pending discards it.
        cycle(0, 1, 0, 1, 0, 0); async_reset(); cycle(1, 0, 0, 1, 0, 0); idle(2);
        // Decrement at zero stays at zero.
        cycle(1, 0, 1, 1, 0, 0); idle(1);

        for (int n = 0; n < 3000; n++) begin
            ld = int'($urandom_range(0, WMAX));
            cycle($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0, ld);
        end
        idle(2);

        @(negedge clk);
        #1;
        check("scoreboard_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/syn_weight_update.md
SYN_WEIGHT_UPDATE -- requirements
Module: syn_weight_update

Interface
REQ-001 Parameter WRES, default 3: synaptic weight resolution in bits; wmax = 2^WRES-1.
REQ-002 Parameter WINIT, default 0: weight value after reset, range 0..wmax.
REQ-003 Port clk  input  1  unit clock for temporal encoding; all state on rising edge.
REQ-004 Port rst  input  1  reset; one clock, asynchronous, active-high.
REQ-005 Port grst  input  1  1-cycle-wide gamma clock pulse marking the end of a gamma cycle.
REQ-006 Port inc  input  1  increment request from the per-synapse STDP logic; may pulse on any cycle.
REQ-007 Port dec  input  1  decrement request from the per-synapse STDP logic; may pulse on any cycle.
REQ-008 Port learn_en  input  1  when low, weight commits are suppressed but requests are still latched and cleared.
REQ-009 Port load_valid  input  1  host weight-load request.
REQ-010 Port load_data  input  WRES  weight value to load.
REQ-011 Port load_ready  output  1  block can accept a load this cycle.
REQ-012 Port weight_out  output  WRES  registered synaptic weight; drives the STDP weight input and the neuron.
REQ-013 Port sat_hi  output  1  weight_out == wmax.
REQ-014 Port sat_lo  output  1  weight_out == 0.
REQ-015 Ports inc_cnt and dec_cnt  output  16 each  commit counters; present only when WUPD_STATS_EN is defined.

Function
REQ-016 Two sticky flags, inc_pend and dec_pend, SHALL be set on any cycle where inc or dec is high, respectively.
REQ-017 The flags SHALL hold until the commit cycle (grst high) or an accepted load.
REQ-018 A commit SHALL happen on the cycle grst is high, using the flags OR'd with that cycle's inc/dec.
REQ-019 Commit rule: inc-only gives weight+1; dec-only gives weight-1; both or neither gives no change.
REQ-020 Arithmetic SHALL saturate: increment at wmax stays wmax; decrement at 0 stays 0; no wrap-around.
REQ-021 Commit latency SHALL be 1: the new weight_out is visible on the cycle after grst.
REQ-022 Both flags SHALL clear on the commit cycle, regardless of learn_en.
REQ-023 inc/dec arriving on the cycle after grst SHALL belong to the new gamma cycle.
REQ-024 If learn_en is low at the commit cycle, weight_out SHALL remain unchanged.
REQ-025 FSM states SHALL be ACCUM (collecting requests), COMMIT (the grst cycle, decoded combinationally) and LOAD (one cycle while an accepted load is written).
REQ-026 FSM transitions: ACCUM -> LOAD on load handshake; LOAD -> ACCUM unconditionally; COMMIT is transient within ACCUM.
REQ-027 load_ready SHALL be high in ACCUM when grst is low, and low in LOAD or when grst is high.
REQ-028 A load SHALL be accepted when load_valid and load_ready are both high.
REQ-029 An accepted load SHALL set weight_out to load_data on the next cycle and clear both flags.
REQ-030 If load_valid is high with grst high, the load SHALL stall until the next ready cycle; that cycle's commit proceeds normally.
REQ-031 load_data greater than wmax is impossible by width; no clamping is required.
REQ-032 sat_hi and sat_lo SHALL be derived from the registered weight_out, with no extra latency.

Reset
REQ-033 On rst high, asynchronously: weight_out=WINIT, inc_pend=dec_pend=0, FSM=ACCUM, counters=0.
REQ-034 load_ready SHALL be 0 while rst is high and SHALL follow REQ-027 from the first cycle after release.
REQ-035 Reset during a pending gamma cycle SHALL discard the pending requests; no commit occurs for that gamma cycle.

Configuration
REQ-036 Macro WUPD_STATS_EN: when defined, inc_cnt and dec_cnt exist.
REQ-037 With WUPD_STATS_EN, each counter SHALL increment on every effective inc or dec commit (learn_en high, net single direction), including saturated commits that leave the weight unchanged.
REQ-038 With WUPD_STATS_EN, each counter SHALL saturate at 16'hFFFF and be unaffected by loads.
REQ-039 Without WUPD_STATS_EN, the ports and their logic SHALL be absent; all other behaviour is identical.

Verification
REQ-040 WRES=3, WINIT=0: one inc pulse mid-gamma, then grst -> weight_out=1 on the cycle after grst; flags cleared.
REQ-041 inc and dec on different cycles within one gamma cycle, then grst -> weight_out unchanged; inc_cnt/dec_cnt unchanged.
REQ-042 Load 7, then inc plus grst -> weight_out stays 7 and sat_hi=1; with WUPD_STATS_EN, inc_cnt=1.
REQ-043 load_valid=1 with load_data=5 asserted in the same cycle as grst -> load_ready=0 that cycle; load accepted on the next cycle; weight_out=5 one cycle later.
REQ-044 learn_en=0 with dec pulse and grst at weight 3 -> weight stays 3; at the next grst with no requests and learn_en=1 -> weight still 3.
REQ-045 rst asserted asynchronously between clock edges while inc_pend is set -> weight_out=WINIT immediately; the following grst with no requests leaves WINIT.
